// File: rtl/switch_word_loader.sv
// Builds a wide control word from board switches, one chunk per debounced button press,
// and commits it atomically once every chunk has been written since the last commit or clear.
module switch_word_loader #(
  parameter int CHUNK_W         = 8,
  parameter int NUM_CHUNKS      = 4,
  parameter int SEL_W           = 2,
  parameter int SW_WIDTH        = 10,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic [SW_WIDTH-1:0]           i_sw,
  input  logic                          i_latch,
  input  logic                          i_auto_mode,
  input  logic                          i_clear,
  output logic [CHUNK_W*NUM_CHUNKS-1:0] o_word,
  output logic [CHUNK_W*NUM_CHUNKS-1:0] o_stage,
  output logic [NUM_CHUNKS-1:0]         o_mask,
  output logic [SEL_W-1:0]              o_ptr,
  output logic                          o_commit,
  output logic                          o_wr
);

  localparam int                WORD_W   = CHUNK_W * NUM_CHUNKS;
  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SEL_W-1:0]  PTR_LAST = SEL_W'(NUM_CHUNKS - 1);

  if (NUM_CHUNKS < 2)                  begin : g_chk_chunks $error("NUM_CHUNKS must be >= 2"); end
  if ((1 << SEL_W) < NUM_CHUNKS)       begin : g_chk_sel    $error("SEL_W too narrow");        end
  if (SW_WIDTH < CHUNK_W + SEL_W)      begin : g_chk_sw     $error("SW_WIDTH too narrow");     end
  if (DEBOUNCE_CYCLES < 1)             begin : g_chk_db     $error("DEBOUNCE_CYCLES < 1");     end

  logic [SW_WIDTH-1:0]   r_sw_s1, r_sw_s2;
  logic                  r_latch_s1, r_latch_s2;
  logic                  r_auto_s1, r_auto_s2;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_db, r_db_d;
  logic [WORD_W-1:0]     r_word, r_stage;
  logic [NUM_CHUNKS-1:0] r_mask;
  logic [SEL_W-1:0]      r_ptr;
  logic                  r_commit, r_wr;

  logic                  w_rise;
  logic [SEL_W-1:0]      w_idx;
  logic                  w_idx_ok;
  logic                  w_write;
  logic                  w_full;
  logic [CHUNK_W-1:0]    w_data;
  logic [NUM_CHUNKS-1:0] w_sel;

  // Switch bits above the data and select fields are synchronised but never consumed.
  if (SW_WIDTH > CHUNK_W + SEL_W) begin : g_unused
    logic w_unused_sw;
    assign w_unused_sw = ^r_sw_s2[SW_WIDTH-1:CHUNK_W+SEL_W];
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sw_s1    <= '0;
      r_sw_s2    <= '0;
      r_latch_s1 <= 1'b0;
      r_latch_s2 <= 1'b0;
      r_auto_s1  <= 1'b0;
      r_auto_s2  <= 1'b0;
    end else begin
      r_sw_s1    <= i_sw;
      r_sw_s2    <= r_sw_s1;
      r_latch_s1 <= i_latch;
      r_latch_s2 <= r_latch_s1;
      r_auto_s1  <= i_auto_mode;
      r_auto_s2  <= r_auto_s1;
    end
  end

  // Any return of the synchronised button to the debounced level restarts the count.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt  <= '0;
      r_db   <= 1'b0;
      r_db_d <= 1'b0;
    end else begin
      r_db_d <= r_db;
      if (r_latch_s2 == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_db  <= r_latch_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_rise   = r_db & ~r_db_d;
    w_idx    = r_auto_s2 ? r_ptr : r_sw_s2[CHUNK_W+SEL_W-1:CHUNK_W];
    w_idx_ok = 32'(w_idx) < NUM_CHUNKS;
    w_write  = w_rise & w_idx_ok & ~i_clear;
    w_full   = &r_mask;
    w_data   = r_sw_s2[CHUNK_W-1:0];
    w_sel    = '0;
    for (int i = 0; i < NUM_CHUNKS; i++) begin
      w_sel[i] = (w_idx == SEL_W'(i));
    end
  end

  // A full mask can only appear the cycle after a write, so commit and write never coincide.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_word   <= '0;
      r_stage  <= '0;
      r_mask   <= '0;
      r_ptr    <= '0;
      r_commit <= 1'b0;
      r_wr     <= 1'b0;
    end else begin
      r_wr     <= w_write;
      r_commit <= w_full & ~i_clear;
      if (i_clear) begin
        r_stage <= '0;
        r_mask  <= '0;
        r_ptr   <= '0;
      end else begin
        if (w_full) begin
          r_word <= r_stage;
          r_mask <= '0;
        end else if (w_write) begin
          r_mask <= r_mask | w_sel;
        end
        if (w_write) begin
          for (int i = 0; i < NUM_CHUNKS; i++) begin
            if (w_sel[i]) r_stage[i*CHUNK_W +: CHUNK_W] <= w_data;
          end
          if (r_auto_s2) r_ptr <= (r_ptr == PTR_LAST) ? '0 : r_ptr + SEL_W'(1);
        end
      end
    end
  end

  assign o_word   = r_word;
  assign o_stage  = r_stage;
  assign o_mask   = r_mask;
  assign o_ptr    = r_ptr;
  assign o_commit = r_commit;
  assign o_wr     = r_wr;

endmodule

// File: tb/tb_switch_word_loader.sv
// Directed bench for switch_word_loader with a short debounce: table of presses plus
// hand-written bounce, clear-collision and reset-mid-press sequences.
module tb_switch_word_loader;

  localparam int DB = 4;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic [9:0]  i_sw;
  logic        i_latch;
  logic        i_auto_mode;
  logic        i_clear;
  logic [31:0] o_word, o_stage;
  logic [3:0]  o_mask;
  logic [1:0]  o_ptr;
  logic        o_commit, o_wr;

  int total = 0;
  int bad   = 0;

  switch_word_loader #(
    .CHUNK_W(8), .NUM_CHUNKS(4), .SEL_W(2), .SW_WIDTH(10), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_sw(i_sw), .i_latch(i_latch),
    .i_auto_mode(i_auto_mode), .i_clear(i_clear), .o_word(o_word), .o_stage(o_stage),
    .o_mask(o_mask), .o_ptr(o_ptr), .o_commit(o_commit), .o_wr(o_wr)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

  typedef struct {
    logic [9:0]  sw;
    logic        auto_m;
    logic        exp_commit;
    logic [3:0]  mask;
    logic [1:0]  ptr;
    logic [31:0] stage;
    logic [31:0] word;
  } vec_t;

  vec_t tbl[16];

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Clean press: hold for 14 cycles, release for 12, tracking wr and commit pulses.
  task automatic press(input logic [9:0] s, input logic exp_commit, input string tag);
    int t_wr = -1;
    int t_c  = -1;
    int nwr  = 0;
    int nc   = 0;
    i_sw    = s;
    i_latch = 1'b1;
    for (int n = 1; n <= 26; n++) begin
      if (n == 15) i_latch = 1'b0;
      step();
      if (o_wr) begin nwr++; if (t_wr < 0) t_wr = n; end
      if (o_commit) begin nc++; if (t_c < 0) t_c = n; end
    end
    chk({tag, " wr_count"}, nwr, 1);
    chk({tag, " wr_latency"}, t_wr, DB + 3);
    chk({tag, " commit_count"}, nc, {31'd0, exp_commit});
    if (exp_commit) chk({tag, " commit_latency"}, t_c, t_wr + 1);
  endtask

  task automatic run_row(input int i);
    string tag;
    tag = $sformatf("row%0d", i);
    i_auto_mode = tbl[i].auto_m;
    press(tbl[i].sw, tbl[i].exp_commit, tag);
    chk({tag, " mask"},  {28'd0, o_mask}, {28'd0, tbl[i].mask});
    chk({tag, " ptr"},   {30'd0, o_ptr},  {30'd0, tbl[i].ptr});
    chk({tag, " stage"}, o_stage, tbl[i].stage);
    chk({tag, " word"},  o_word,  tbl[i].word);
  endtask

  initial begin
    int nwr, nc, t;

    // addressed mode
    tbl[0]  = '{10'h021, 1'b0, 1'b0, 4'b0001, 2'd0, 32'h00000021, 32'h00000000};
    tbl[1]  = '{10'h143, 1'b0, 1'b0, 4'b0011, 2'd0, 32'h00004321, 32'h00000000};
    tbl[2]  = '{10'h265, 1'b0, 1'b0, 4'b0111, 2'd0, 32'h00654321, 32'h00000000};
    tbl[3]  = '{10'h387, 1'b0, 1'b1, 4'b0000, 2'd0, 32'h87654321, 32'h87654321};
    // auto mode, select bits deliberately scrambled
    tbl[4]  = '{10'h1A1, 1'b1, 1'b0, 4'b0001, 2'd1, 32'h876543A1, 32'h87654321};
    tbl[5]  = '{10'h0B2, 1'b1, 1'b0, 4'b0011, 2'd2, 32'h8765B2A1, 32'h87654321};
    tbl[6]  = '{10'h3C3, 1'b1, 1'b0, 4'b0111, 2'd3, 32'h87C3B2A1, 32'h87654321};
    tbl[7]  = '{10'h2D4, 1'b1, 1'b1, 4'b0000, 2'd0, 32'hD4C3B2A1, 32'hD4C3B2A1};
    // rewrite chunk 2, then partial update
    tbl[8]  = '{10'h211, 1'b0, 1'b0, 4'b0100, 2'd0, 32'hD411B2A1, 32'hD4C3B2A1};
    tbl[9]  = '{10'h222, 1'b0, 1'b0, 4'b0100, 2'd0, 32'hD422B2A1, 32'hD4C3B2A1};
    tbl[10] = '{10'h021, 1'b0, 1'b0, 4'b0101, 2'd0, 32'hD422B221, 32'hD4C3B2A1};
    tbl[11] = '{10'h143, 1'b0, 1'b0, 4'b0111, 2'd0, 32'hD4224321, 32'hD4C3B2A1};
    tbl[12] = '{10'h387, 1'b0, 1'b1, 4'b0000, 2'd0, 32'h87224321, 32'h87224321};
    // auto mode after the bounced chunk-0 write (stage 0x872243F5, mask 0001)
    tbl[13] = '{10'h311, 1'b1, 1'b0, 4'b0001, 2'd1, 32'h87224311, 32'h87224321};
    tbl[14] = '{10'h022, 1'b1, 1'b0, 4'b0011, 2'd2, 32'h87222211, 32'h87224321};
    tbl[15] = '{10'h133, 1'b1, 1'b0, 4'b0111, 2'd3, 32'h87332211, 32'h87224321};

    i_reset_n   = 1'b0;
    i_sw        = '0;
    i_latch     = 1'b0;
    i_auto_mode = 1'b0;
    i_clear     = 1'b0;
    repeat (3) step();
    chk("reset word",   o_word, 0);
    chk("reset stage",  o_stage, 0);
    chk("reset mask",   {28'd0, o_mask}, 0);
    chk("reset ptr",    {30'd0, o_ptr}, 0);
    chk("reset commit", {31'd0, o_commit}, 0);
    chk("reset wr",     {31'd0, o_wr}, 0);
    i_reset_n = 1'b1;
    repeat (2) step();

    for (int i = 0; i <= 12; i++) run_row(i);

    // bounce: toggle every 2 cycles for 20 cycles, then hold high
    i_auto_mode = 1'b0;
    i_sw = 10'h0F5;
    nwr = 0;
    for (int k = 0; k < 10; k++) begin
      i_latch = (k % 2 == 0);
      repeat (2) begin step(); if (o_wr) nwr++; end
    end
    chk("bounce no_wr_while_toggling", nwr, 0);
    i_latch = 1'b1;
    t = -1;
    for (int n = 1; n <= 26; n++) begin
      if (n == 15) i_latch = 1'b0;
      step();
      if (o_wr) begin nwr++; if (t < 0) t = n; end
    end
    chk("bounce wr_count", nwr, 1);
    chk("bounce wr_latency", t, DB + 3);
    chk("bounce mask", {28'd0, o_mask}, 32'h1);
    chk("bounce stage", o_stage, 32'h872243F5);

    for (int i = 13; i <= 15; i++) run_row(i);

    // clear lands on the same edge as the 4th write
    i_sw = 10'h044;
    i_latch = 1'b1;
    nwr = 0;
    nc = 0;
    repeat (DB + 2) begin step(); if (o_wr) nwr++; if (o_commit) nc++; end
    i_clear = 1'b1;
    step();
    i_clear = 1'b0;
    chk("clear wr", {31'd0, o_wr}, 0);
    chk("clear stage", o_stage, 0);
    chk("clear mask", {28'd0, o_mask}, 0);
    chk("clear ptr", {30'd0, o_ptr}, 0);
    for (int n = 0; n < 16; n++) begin
      if (n == 6) i_latch = 1'b0;
      step();
      if (o_wr) nwr++;
      if (o_commit) nc++;
    end
    chk("clear wr_count", nwr, 0);
    chk("clear commit_count", nc, 0);
    chk("clear word_kept", o_word, 32'h87224321);

    // asynchronous reset mid-debounce with button held
    i_auto_mode = 1'b0;
    i_sw = 10'h2E7;
    i_latch = 1'b1;
    repeat (4) step();
    i_reset_n = 1'b0;
    #1;
    chk("midreset word",   o_word, 0);
    chk("midreset stage",  o_stage, 0);
    chk("midreset mask",   {28'd0, o_mask}, 0);
    chk("midreset ptr",    {30'd0, o_ptr}, 0);
    chk("midreset commit", {31'd0, o_commit}, 0);
    chk("midreset wr",     {31'd0, o_wr}, 0);
    repeat (2) step();
    i_reset_n = 1'b1;
    nwr = 0;
    t = -1;
    for (int n = 1; n <= 26; n++) begin
      if (n == 15) i_latch = 1'b0;
      step();
      if (o_wr) begin nwr++; if (t < 0) t = n; end
    end
    chk("postreset wr_count", nwr, 1);
    chk("postreset wr_latency", t, DB + 3);
    chk("postreset stage", o_stage, 32'h00E70000);
    chk("postreset mask", {28'd0, o_mask}, 32'h4);
    chk("postreset word", o_word, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
